// File: rtl/uart_cmd_loader_pkg.sv
// Shared opcodes and FSM state encoding for the UART debug command loader.
package uart_cmd_loader_pkg;

    localparam logic [7:0] OP_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] OP_RUN  = 8'h52;  // 'R'
    localparam logic [7:0] OP_STEP = 8'h53;  // 'S'
    localparam logic [7:0] OP_CRST = 8'h43;  // 'C'
    localparam logic [7:0] OP_HALT = 8'h48;  // 'H'

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StLoad,
        StWrite,
        StRun,
        StError
    } state_e;

endpackage

// File: rtl/uart_cmd_loader_rx_byte_strobe.sv
// Turns the receiver's ready level into a byte strobe held in a 1-deep pending register.
module rx_byte_strobe #(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_ready,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 consume,
    output logic                 pending,
    output logic [DATA_BITS-1:0] data,
    output logic                 overrun
);

    logic                 prev_q;
    logic                 pending_q, pending_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 rise;

    assign rise    = rx_ready & ~prev_q;
    // A new byte landing on an unconsumed one overwrites it.
    assign overrun = rise & pending_q & ~consume;
    assign pending = pending_q;
    assign data    = data_q;

    // Next-state for the pending byte: capture on rising ready, clear once consumed.
    always_comb begin
        pending_d = pending_q;
        data_d    = data_q;
        if (rise) begin
            pending_d = 1'b1;
            data_d    = rx_data;
        end else if (consume) begin
            pending_d = 1'b0;
        end
    end

    // State registers; prev starts high so a ready level present at reset release is ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q    <= 1'b1;
            pending_q <= 1'b0;
            data_q    <= '0;
        end else begin
            prev_q    <= rx_ready;
            pending_q <= pending_d;
            data_q    <= data_d;
        end
    end

endmodule

// File: rtl/uart_cmd_loader.sv
// Debug command sequencer: loads instruction words from UART bytes and drives CPU controls.
module uart_cmd_loader
    import uart_cmd_loader_pkg::*;
#(
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned WORD_BITS      = 32,
    parameter int unsigned ADDR_BITS      = 10,
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_rx_ready,
    input  logic [DATA_BITS-1:0] i_rx_data,
    input  logic                 i_cpu_halt,
    output logic                 o_imem_we,
    output logic [ADDR_BITS-1:0] o_imem_addr,
    output logic [WORD_BITS-1:0] o_imem_data,
    output logic                 o_cpu_enable,
    output logic                 o_cpu_step,
    output logic                 o_cpu_reset,
    output logic                 o_busy,
    output logic                 o_error
);

    localparam int unsigned BYTES_PER_WORD = WORD_BITS / DATA_BITS;
    localparam int unsigned CNT_BITS       = $clog2(BYTES_PER_WORD);
    localparam int unsigned TMR_BITS       = $clog2(TIMEOUT_CYCLES);

    state_e               state_q, state_d;
    logic [WORD_BITS-1:0] word_q, word_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] left_q, left_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [TMR_BITS-1:0]  timer_q, timer_d;
    logic                 en_q, en_d;
    logic                 step_q, step_d;
    logic                 crst_q, crst_d;
    logic                 err_q, err_d;

    logic                 rx_pending;
    logic [DATA_BITS-1:0] rx_byte;
    logic                 rx_overrun;
    logic                 byte_valid;
    logic                 timeout;

    // Bytes wait in the pending register while a word is being written.
    assign byte_valid = rx_pending && (state_q != StWrite);
    assign timeout    = (timer_q == TMR_BITS'(TIMEOUT_CYCLES - 1));

    rx_byte_strobe #(
        .DATA_BITS(DATA_BITS)
    ) u_strobe (
        .clk     (clk),
        .reset   (reset),
        .rx_ready(i_rx_ready),
        .rx_data (i_rx_data),
        .consume (byte_valid),
        .pending (rx_pending),
        .data    (rx_byte),
        .overrun (rx_overrun)
    );

    // Command FSM next-state, datapath updates and registered control pulses.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        addr_d  = addr_q;
        left_d  = left_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        err_d   = err_q;
        step_d  = 1'b0;
        crst_d  = 1'b0;
        timer_d = '0;

        unique case (state_q)
            StIdle: begin
                if (byte_valid) begin
                    case (rx_byte)
                        OP_LOAD: state_d = StLen;
                        OP_RUN: begin
                            state_d = StRun;
                            en_d    = 1'b1;
                        end
                        OP_STEP: step_d = 1'b1;
                        OP_CRST: begin
                            crst_d = 1'b1;
                            addr_d = '0;
                            err_d  = 1'b0;
                        end
                        OP_HALT: ;
                        default: state_d = StError;
                    endcase
                end
            end
            StLen: begin
                if (byte_valid) begin
                    if (rx_byte == '0) begin
                        state_d = StError;
                    end else begin
                        left_d  = rx_byte;
                        addr_d  = '0;
                        cnt_d   = '0;
                        state_d = StLoad;
                    end
                end else if (timeout) begin
                    state_d = StError;
                end
                timer_d = byte_valid ? '0 : timer_q + TMR_BITS'(1);
            end
            StLoad: begin
                if (byte_valid) begin
                    word_d = {word_q[WORD_BITS-DATA_BITS-1:0], rx_byte};
                    if (cnt_q == CNT_BITS'(BYTES_PER_WORD - 1)) begin
                        cnt_d   = '0;
                        state_d = StWrite;
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end else if (timeout) begin
                    state_d = StError;
                end
                timer_d = byte_valid ? '0 : timer_q + TMR_BITS'(1);
            end
            StWrite: begin
                addr_d  = addr_q + ADDR_BITS'(1);
                left_d  = left_q - DATA_BITS'(1);
                state_d = (left_q == DATA_BITS'(1)) ? StIdle : StLoad;
            end
            StRun: begin
                if (i_cpu_halt || (byte_valid && rx_byte == OP_HALT)) begin
                    en_d    = 1'b0;
                    state_d = StIdle;
                end
            end
            StError: begin
                err_d   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (rx_overrun) begin
            err_d = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            word_q  <= '0;
            addr_q  <= '0;
            left_q  <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            en_q    <= 1'b0;
            step_q  <= 1'b0;
            crst_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            en_q    <= en_d;
            step_q  <= step_d;
            crst_q  <= crst_d;
            err_q   <= err_d;
        end
    end

    assign o_imem_we    = (state_q == StWrite);
    assign o_imem_addr  = addr_q;
    assign o_imem_data  = word_q;
    assign o_cpu_enable = en_q;
    assign o_cpu_step   = step_q;
    assign o_cpu_reset  = crst_q;
    assign o_busy       = (state_q != StIdle);
    assign o_error      = err_q;

endmodule

// File: tb/tb_uart_cmd_loader.sv
// Randomized bench for uart_cmd_loader with a cycle-level behavioural model and literal pins.
module tb_uart_cmd_loader;

    localparam int T = 100;
    localparam int MI = 0, ML = 1, MD = 2, MW = 3, MR = 4, ME = 5;

    logic        clk;
    logic        reset;
    logic        i_rx_ready;
    logic [7:0]  i_rx_data;
    logic        i_cpu_halt;
    logic        o_imem_we;
    logic [9:0]  o_imem_addr;
    logic [31:0] o_imem_data;
    logic        o_cpu_enable;
    logic        o_cpu_step;
    logic        o_cpu_reset;
    logic        o_busy;
    logic        o_error;

    uart_cmd_loader #(
        .DATA_BITS     (8),
        .WORD_BITS     (32),
        .ADDR_BITS     (10),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_rx_ready  (i_rx_ready),
        .i_rx_data   (i_rx_data),
        .i_cpu_halt  (i_cpu_halt),
        .o_imem_we   (o_imem_we),
        .o_imem_addr (o_imem_addr),
        .o_imem_data (o_imem_data),
        .o_cpu_enable(o_cpu_enable),
        .o_cpu_step  (o_cpu_step),
        .o_cpu_reset (o_cpu_reset),
        .o_busy      (o_busy),
        .o_error     (o_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int chk_cnt = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model state
    int          m_mode = MI;
    bit          m_pend, m_prev, m_got, m_ok = 1'b0;
    logic [7:0]  m_pb, m_b;
    int          m_left, m_nb, m_addr, m_quiet, m_nxt;
    logic [31:0] m_word;
    bit          m_en, m_step, m_rst, m_err;

    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                m_mode = MI; m_pend = 0; m_prev = 1; m_pb = 0; m_left = 0; m_nb = 0;
                m_addr = 0; m_quiet = 0; m_word = 0; m_en = 0; m_step = 0; m_rst = 0;
                m_err = 0; m_ok = 1;
            end else begin
                m_got  = m_pend && (m_mode != MW);
                m_b    = m_pb;
                m_nxt  = m_mode;
                m_step = 0;
                m_rst  = 0;
                case (m_mode)
                    MI: if (m_got) begin
                        if (m_b == 8'h4C) m_nxt = ML;
                        else if (m_b == 8'h52) begin m_nxt = MR; m_en = 1; end
                        else if (m_b == 8'h53) m_step = 1;
                        else if (m_b == 8'h43) begin m_rst = 1; m_addr = 0; m_err = 0; end
                        else if (m_b != 8'h48) m_nxt = ME;
                    end
                    ML: if (m_got) begin
                        if (m_b == 8'h00) m_nxt = ME;
                        else begin m_left = int'(m_b); m_addr = 0; m_nb = 0; m_nxt = MD; end
                    end else if (m_quiet == T - 1) m_nxt = ME;
                    MD: if (m_got) begin
                        m_word = (m_word << 8) | 32'(m_b);
                        m_nb++;
                        if (m_nb == 4) begin m_nb = 0; m_nxt = MW; end
                    end else if (m_quiet == T - 1) m_nxt = ME;
                    MW: begin
                        m_addr = (m_addr + 1) % 1024;
                        m_left--;
                        m_nxt = (m_left == 0) ? MI : MD;
                    end
                    MR: if (i_cpu_halt || (m_got && m_b == 8'h48)) begin
                        m_en = 0;
                        m_nxt = MI;
                    end
                    default: begin m_err = 1; m_nxt = MI; end
                endcase
                if (m_mode == ML || m_mode == MD) m_quiet = m_got ? 0 : m_quiet + 1;
                else m_quiet = 0;
                if (i_rx_ready && !m_prev) begin
                    if (m_pend && !m_got) m_err = 1;
                    m_pend = 1;
                    m_pb   = i_rx_data;
                end else if (m_got) begin
                    m_pend = 0;
                end
                m_prev = i_rx_ready;
                m_mode = m_nxt;
            end
        end
    end

    // Write log and pulse counters observed from the DUT
    logic [41:0] wlog[$];
    int en_cnt = 0, step_cnt = 0, rst_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (o_imem_we === 1'b1) wlog.push_back({o_imem_addr, o_imem_data});
            if (o_cpu_enable === 1'b1) en_cnt++;
            if (o_cpu_step === 1'b1) step_cnt++;
            if (o_cpu_reset === 1'b1) rst_cnt++;
            if (m_ok) begin
                check("busy", o_busy, m_mode != MI);
                check("error", o_error, m_err);
                check("cpu_enable", o_cpu_enable, m_en);
                check("cpu_step", o_cpu_step, m_step);
                check("cpu_reset", o_cpu_reset, m_rst);
                check("imem_we", o_imem_we, m_mode == MW);
                if (m_mode == MW) begin
                    check("imem_addr", o_imem_addr, m_addr[9:0]);
                    check("imem_data", o_imem_data, m_word);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, input int lo = 2, input int hi = 4);
        i_rx_ready = 1'b0;
        repeat (lo) tick();
        i_rx_data  = b;
        i_rx_ready = 1'b1;
        repeat (hi) tick();
    endtask

    int n0, w, k, n;

    initial begin
        reset      = 1'b0;
        i_rx_ready = 1'b1;       // ready already high across reset release
        i_rx_data  = 8'h53;
        i_cpu_halt = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("reset_we", o_imem_we, 0);
        check("reset_addr", o_imem_addr, 0);
        check("reset_data", o_imem_data, 0);
        check("reset_busy", o_busy, 0);
        check("reset_error", o_error, 0);
        check("reset_enable", o_cpu_enable, 0);
        repeat (5) tick();
        check("ready_at_reset_no_step", step_cnt, 0);
        check("ready_at_reset_idle", o_busy, 0);

        // Two-word load
        send_byte(8'h4C); send_byte(8'h02);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'h01); send_byte(8'h23); send_byte(8'h45); send_byte(8'h67);
        repeat (4) tick();
        check("load_count", wlog.size(), 2);
        if (wlog.size() >= 2) begin
            check("load_word0", wlog[0], {10'd0, 32'hDEADBEEF});
            check("load_word1", wlog[1], {10'd1, 32'h01234567});
        end
        check("load_busy", o_busy, 0);
        check("load_error", o_error, 0);

        // Run until halt after 20 cycles
        send_byte(8'h52);
        w = 0;
        while (o_cpu_enable !== 1'b1 && w < 20) begin tick(); w++; end
        check("run_enable_rise", o_cpu_enable, 1);
        en_cnt = 0;
        repeat (20) tick();
        i_cpu_halt = 1'b1;
        tick();
        i_cpu_halt = 1'b0;
        repeat (3) tick();
        check("run_enable_cycles", en_cnt, 21);
        check("run_exit_enable", o_cpu_enable, 0);
        check("run_exit_idle", o_busy, 0);

        // Step then CPU reset, then a fresh load starts at address 0
        step_cnt = 0; rst_cnt = 0;
        send_byte(8'h53); send_byte(8'h43);
        repeat (3) tick();
        check("step_pulses", step_cnt, 1);
        check("crst_pulses", rst_cnt, 1);
        n0 = wlog.size();
        send_byte(8'h4C); send_byte(8'h01);
        send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
        repeat (4) tick();
        check("reload_count", wlog.size(), n0 + 1);
        if (wlog.size() > n0) check("reload_word", wlog[n0], {10'd0, 32'hCAFEF00D});

        // Timeout mid-word
        n0 = wlog.size();
        send_byte(8'h4C); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
        repeat (T + 20) tick();
        check("timeout_error", o_error, 1);
        check("timeout_idle", o_busy, 0);
        check("timeout_no_write", wlog.size(), n0);
        send_byte(8'h43);
        repeat (2) tick();
        check("crst_clears_error", o_error, 0);

        // Bad opcode, zero length
        send_byte(8'h7F);
        repeat (2) tick();
        check("bad_opcode_error", o_error, 1);
        send_byte(8'h43);
        repeat (2) tick();
        check("bad_opcode_cleared", o_error, 0);
        send_byte(8'h4C); send_byte(8'h00);
        repeat (3) tick();
        check("zero_len_error", o_error, 1);
        check("zero_len_no_write", wlog.size(), n0);
        send_byte(8'h43);

        // Back-to-back bytes, next word's first byte arriving right at the write
        n0 = wlog.size();
        send_byte(8'h4C, 1, 1); send_byte(8'h02, 1, 1);
        send_byte(8'h11, 1, 1); send_byte(8'h22, 1, 1);
        send_byte(8'h33, 1, 1); send_byte(8'h44, 1, 1);
        send_byte(8'h55, 1, 1); send_byte(8'h66, 1, 1);
        send_byte(8'h77, 1, 1); send_byte(8'h88, 1, 1);
        repeat (6) tick();
        check("tight_count", wlog.size(), n0 + 2);
        if (wlog.size() >= n0 + 2) begin
            check("tight_word0", wlog[n0], {10'd0, 32'h11223344});
            check("tight_word1", wlog[n0 + 1], {10'd1, 32'h55667788});
        end
        check("tight_error", o_error, 0);

        // Reset during a load aborts without a write
        n0 = wlog.size();
        send_byte(8'h4C); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        check("reset_midload_no_write", wlog.size(), n0);
        check("reset_midload_idle", o_busy, 0);

        // Randomized command traffic against the model
        for (int it = 0; it < 250; it++) begin
            k = $urandom_range(0, 9);
            case (k)
                0, 1, 2: begin
                    n = $urandom_range(1, 3);
                    send_byte(8'h4C, $urandom_range(1, 3), $urandom_range(1, 4));
                    send_byte(8'(n), $urandom_range(1, 3), $urandom_range(1, 4));
                    for (int j = 0; j < 4 * n; j++)
                        send_byte(8'($urandom), $urandom_range(1, 3), $urandom_range(1, 4));
                end
                3: begin
                    send_byte(8'h52);
                    repeat ($urandom_range(3, 25)) tick();
                    case ($urandom_range(0, 2))
                        0: begin i_cpu_halt = 1'b1; tick(); i_cpu_halt = 1'b0; end
                        1: send_byte(8'h48);
                        default: begin
                            i_rx_ready = 1'b0;
                            tick();
                            i_rx_data  = 8'h48;
                            i_rx_ready = 1'b1;
                            tick();
                            i_cpu_halt = 1'b1;
                            tick();
                            i_cpu_halt = 1'b0;
                        end
                    endcase
                end
                4: send_byte(8'h53, $urandom_range(1, 3), $urandom_range(1, 4));
                5: send_byte(8'h43, $urandom_range(1, 3), $urandom_range(1, 4));
                6: send_byte(8'($urandom), $urandom_range(1, 3), $urandom_range(1, 4));
                7: begin i_cpu_halt = 1'b1; tick(); i_cpu_halt = 1'b0; end
                8: repeat ($urandom_range(1, 10)) tick();
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        send_byte(8'h4C);
                        send_byte(8'h01);
                        repeat ($urandom_range(0, 3)) send_byte(8'($urandom));
                        repeat (T + 10) tick();
                    end else begin
                        send_byte(8'h48);
                    end
                end
            endcase
        end
        i_cpu_halt = 1'b1;
        tick();
        i_cpu_halt = 1'b0;
        repeat (5) tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
